// File: rtl/axil_pkg.sv
// Shared definitions for the AXI4-Lite register slave: response codes and FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {
        W_IDLE,
        W_RESP
    } wr_state_t;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rd_state_t;

endpackage

// File: rtl/axil_reg_slave_if.sv
// AXI4-Lite slave-side channel bundle (AW, W, B, AR, R) with master/slave views.
// Latency: n/a (wires only).
// Backpressure: plain valid/ready on every channel.
interface axil_reg_slave_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) ();

    logic                  s_awvalid;
    logic                  s_awready;
    logic [ADDR_W-1:0]     s_awaddr;

    logic                  s_wvalid;
    logic                  s_wready;
    logic [DATA_W-1:0]     s_wdata;
    logic [DATA_W/8-1:0]   s_wstrb;

    logic                  s_bvalid;
    logic                  s_bready;
    logic [1:0]            s_bresp;

    logic                  s_arvalid;
    logic                  s_arready;
    logic [ADDR_W-1:0]     s_araddr;

    logic                  s_rvalid;
    logic                  s_rready;
    logic [DATA_W-1:0]     s_rdata;
    logic [1:0]            s_rresp;

    modport master (
        output s_awvalid, s_awaddr,
        input  s_awready,
        output s_wvalid, s_wdata, s_wstrb,
        input  s_wready,
        input  s_bvalid, s_bresp,
        output s_bready,
        output s_arvalid, s_araddr,
        input  s_arready,
        input  s_rvalid, s_rdata, s_rresp,
        output s_rready
    );

    modport slave (
        input  s_awvalid, s_awaddr,
        output s_awready,
        input  s_wvalid, s_wdata, s_wstrb,
        output s_wready,
        output s_bvalid, s_bresp,
        input  s_bready,
        input  s_arvalid, s_araddr,
        output s_arready,
        output s_rvalid, s_rdata, s_rresp,
        input  s_rready
    );

endinterface

// File: rtl/axil_reg_bank.sv
// Register storage with byte-lane merge; AXIL_SLV_WSTRB_EN enables per-byte strobes, otherwise full words.
// Latency: write visible on i_/o_reg_q one cycle after i_wr_en.
// Backpressure: none, accepts a write every cycle.
module axil_reg_bank #(
    parameter int DATA_W = 32,
    parameter int NREGS  = 16,
    parameter int IDX_W  = $clog2(NREGS)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_wr_en,
    input  logic [IDX_W-1:0]        i_wr_idx,
    input  logic [DATA_W-1:0]       i_wr_data,
    input  logic [DATA_W/8-1:0]     i_wr_strb,
    output logic [NREGS*DATA_W-1:0] o_reg_q
);

    localparam int NBYTES = DATA_W / 8;

    logic [DATA_W-1:0] r_regs [NREGS];
    logic [NBYTES-1:0] w_be;

`ifdef AXIL_SLV_WSTRB_EN
    assign w_be = i_wr_strb;
`else
    // Strobes are ignored in this build: every write replaces the whole word.
    assign w_be = '1;
    wire w_unused_strb = ^i_wr_strb;
`endif

    // Storage: cleared on reset, byte lanes merged on a committed write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NREGS; k++) begin
                r_regs[k] <= '0;
            end
        end else if (i_wr_en) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (w_be[b]) begin
                    r_regs[i_wr_idx][b*8 +: 8] <= i_wr_data[b*8 +: 8];
                end
            end
        end
    end

    for (genvar g = 0; g < NREGS; g++) begin : g_flat
        assign o_reg_q[g*DATA_W +: DATA_W] = r_regs[g];
    end

endmodule

// File: rtl/axil_reg_slave.sv
// AXI4-Lite register slave: independent write/read FSMs, address decode, storage in axil_reg_bank (AXIL_SLV_WSTRB_EN enables byte strobes).
// Latency: B one cycle after both AW and W are held; R one cycle after the AR handshake.
// Backpressure: readies drop while a beat is held or a response is pending; B/R hold until bready/rready.
module axil_reg_slave
    import axil_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int NREGS  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    axil_reg_slave_if.slave         s,
    output logic [NREGS*DATA_W-1:0] reg_q
);

    localparam int IDX_LSB = $clog2(DATA_W / 8);
    localparam int IDX_W   = $clog2(NREGS);
    localparam int IDX_TOP = IDX_LSB + IDX_W;

    // ---------------- write side ----------------
    wr_state_t             r_wst;
    logic                  r_awready;
    logic                  r_wready;
    logic                  r_aw_held;
    logic                  r_w_held;
    logic [ADDR_W-1:0]     r_awaddr;
    logic [DATA_W-1:0]     r_wdata;
    logic [DATA_W/8-1:0]   r_wstrb;
    logic                  r_bvalid;
    logic [1:0]            r_bresp;

    logic                  w_aw_hs;
    logic                  w_w_hs;
    logic                  w_commit;
    logic [ADDR_W-1:0]     w_awaddr;
    logic [DATA_W-1:0]     w_wdata;
    logic [DATA_W/8-1:0]   w_wstrb;
    logic [IDX_W-1:0]      w_aw_idx;
    logic                  w_aw_oor;

    assign w_aw_hs  = s.s_awvalid & r_awready;
    assign w_w_hs   = s.s_wvalid  & r_wready;

    // A held beat wins over the bus; its ready is low so the bus beat cannot also be taken.
    assign w_awaddr = r_aw_held ? r_awaddr : s.s_awaddr;
    assign w_wdata  = r_w_held  ? r_wdata  : s.s_wdata;
    assign w_wstrb  = r_w_held  ? r_wstrb  : s.s_wstrb;

    assign w_aw_idx = w_awaddr[IDX_LSB +: IDX_W];
    assign w_aw_oor = |(w_awaddr >> IDX_TOP);

    assign w_commit = (r_wst == W_IDLE) & (w_aw_hs | r_aw_held) & (w_w_hs | r_w_held);

    // Write FSM: collect AW and W in any order, commit, then hold B until bready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wst     <= W_IDLE;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_awaddr  <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_bvalid  <= 1'b0;
            r_bresp   <= RESP_OKAY;
        end else begin
            case (r_wst)
                W_IDLE: begin
                    if (w_commit) begin
                        r_wst     <= W_RESP;
                        r_awready <= 1'b0;
                        r_wready  <= 1'b0;
                        r_aw_held <= 1'b0;
                        r_w_held  <= 1'b0;
                        r_bvalid  <= 1'b1;
                        r_bresp   <= w_aw_oor ? RESP_SLVERR : RESP_OKAY;
                    end else begin
                        if (w_aw_hs) begin
                            r_aw_held <= 1'b1;
                            r_awaddr  <= s.s_awaddr;
                            r_awready <= 1'b0;
                        end else begin
                            r_awready <= ~r_aw_held;
                        end
                        if (w_w_hs) begin
                            r_w_held  <= 1'b1;
                            r_wdata   <= s.s_wdata;
                            r_wstrb   <= s.s_wstrb;
                            r_wready  <= 1'b0;
                        end else begin
                            r_wready  <= ~r_w_held;
                        end
                    end
                end
                W_RESP: begin
                    if (s.s_bready) begin
                        r_wst     <= W_IDLE;
                        r_bvalid  <= 1'b0;
                        r_bresp   <= RESP_OKAY;
                        r_awready <= 1'b1;
                        r_wready  <= 1'b1;
                    end
                end
                default: r_wst <= W_IDLE;
            endcase
        end
    end

    assign s.s_awready = r_awready;
    assign s.s_wready  = r_wready;
    assign s.s_bvalid  = r_bvalid;
    assign s.s_bresp   = r_bresp;

    // ---------------- storage ----------------
    axil_reg_bank #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS),
        .IDX_W  (IDX_W)
    ) u_bank (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_wr_en   (w_commit & ~w_aw_oor),
        .i_wr_idx  (w_aw_idx),
        .i_wr_data (w_wdata),
        .i_wr_strb (w_wstrb),
        .o_reg_q   (reg_q)
    );

    // ---------------- read side ----------------
    rd_state_t             r_rst;
    logic                  r_arready;
    logic                  r_rvalid;
    logic [DATA_W-1:0]     r_rdata;
    logic [1:0]            r_rresp;

    logic                  w_ar_hs;
    logic [IDX_W-1:0]      w_ar_idx;
    logic                  w_ar_oor;
    logic [DATA_W-1:0]     w_rd_word;

    assign w_ar_hs   = s.s_arvalid & r_arready;
    assign w_ar_idx  = s.s_araddr[IDX_LSB +: IDX_W];
    assign w_ar_oor  = |(s.s_araddr >> IDX_TOP);
    // Sampled from the bank's current contents, so a write committing on the same edge is not seen.
    assign w_rd_word = reg_q[w_ar_idx*DATA_W +: DATA_W];

    // Read FSM: capture data on AR, hold R until rready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rst     <= R_IDLE;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
            r_rresp   <= RESP_OKAY;
        end else begin
            case (r_rst)
                R_IDLE: begin
                    if (w_ar_hs) begin
                        r_rst     <= R_DATA;
                        r_arready <= 1'b0;
                        r_rvalid  <= 1'b1;
                        r_rdata   <= w_ar_oor ? '0 : w_rd_word;
                        r_rresp   <= w_ar_oor ? RESP_SLVERR : RESP_OKAY;
                    end else begin
                        r_arready <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (s.s_rready) begin
                        r_rst     <= R_IDLE;
                        r_rvalid  <= 1'b0;
                        r_arready <= 1'b1;
                    end
                end
                default: r_rst <= R_IDLE;
            endcase
        end
    end

    assign s.s_arready = r_arready;
    assign s.s_rvalid  = r_rvalid;
    assign s.s_rdata   = r_rdata;
    assign s.s_rresp   = r_rresp;

endmodule

// File: tb/tb_axil_reg_slave.sv
// Directed bench for axil_reg_slave (32-bit data, 16 registers) with hand-computed expectations.
// Latency: checks B/R timing against the one-cycle response latency.
// Backpressure: exercises held beats, stalled bready and reset mid-transaction.
module tb_axil_reg_slave;
    import axil_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    logic [16*32-1:0] reg_q;

    always #5 clk = ~clk;

    axil_reg_slave_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    axil_reg_slave #(.ADDR_W(32), .DATA_W(32), .NREGS(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .s     (bus),
        .reg_q (reg_q)
    );

    int n_chk  = 0;
    int n_fail = 0;
    logic [31:0] m [16];

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_regs(input string tag);
        for (int k = 0; k < 16; k++) begin
            check_eq($sformatf("%s_reg%0d", tag, k), {32'h0, reg_q[k*32 +: 32]}, {32'h0, m[k]});
        end
    endtask

    task automatic axi_write(input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] st, output logic [1:0] resp);
        int n;
        bus.s_awvalid = 1'b1; bus.s_awaddr = a;
        bus.s_wvalid  = 1'b1; bus.s_wdata  = d; bus.s_wstrb = st;
        @(posedge clk); #1;
        bus.s_awvalid = 1'b0; bus.s_wvalid = 1'b0;
        check_eq("wr_bvalid_lat", {63'h0, bus.s_bvalid}, 64'h1);
        n = 0;
        while (!bus.s_bvalid && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        resp = bus.s_bresp;
        bus.s_bready = 1'b1;
        @(posedge clk); #1;
        bus.s_bready = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
        int n;
        bus.s_arvalid = 1'b1; bus.s_araddr = a;
        @(posedge clk); #1;
        bus.s_arvalid = 1'b0;
        check_eq("rd_rvalid_lat", {63'h0, bus.s_rvalid}, 64'h1);
        n = 0;
        while (!bus.s_rvalid && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        d = bus.s_rdata;
        resp = bus.s_rresp;
        bus.s_rready = 1'b1;
        @(posedge clk); #1;
        bus.s_rready = 1'b0;
    endtask

    task automatic check_readies(input string tag, input logic exp);
        check_eq({tag, "_awready"}, {63'h0, bus.s_awready}, {63'h0, exp});
        check_eq({tag, "_wready"},  {63'h0, bus.s_wready},  {63'h0, exp});
        check_eq({tag, "_arready"}, {63'h0, bus.s_arready}, {63'h0, exp});
    endtask

    // Watchdog so a stuck handshake still ends the run.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  resp;
        logic [31:0] rd;

        for (int k = 0; k < 16; k++) m[k] = 32'h0;
        bus.s_awvalid = 0; bus.s_awaddr = 0;
        bus.s_wvalid  = 0; bus.s_wdata  = 0; bus.s_wstrb = 0;
        bus.s_bready  = 0;
        bus.s_arvalid = 0; bus.s_araddr = 0;
        bus.s_rready  = 0;

        // Reset state
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check_readies("rst", 1'b0);
        check_eq("rst_bvalid", {63'h0, bus.s_bvalid}, 64'h0);
        check_eq("rst_rvalid", {63'h0, bus.s_rvalid}, 64'h0);
        check_eq("rst_bresp",  {62'h0, bus.s_bresp},  64'h0);
        check_eq("rst_rresp",  {62'h0, bus.s_rresp},  64'h0);
        check_eq("rst_rdata",  {32'h0, bus.s_rdata},  64'h0);
        check_regs("rst");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        check_readies("post_rst", 1'b1);

        // Same-cycle AW+W to reg2, read back
        axi_write(32'h08, 32'hDEADBEEF, 4'hF, resp);
        m[2] = 32'hDEADBEEF;
        check_eq("w08_bresp", {62'h0, resp}, {62'h0, RESP_OKAY});
        check_eq("w08_reg2", {32'h0, reg_q[2*32 +: 32]}, 64'hDEADBEEF);
        axi_read(32'h08, rd, resp);
        check_eq("r08_data", {32'h0, rd}, 64'hDEADBEEF);
        check_eq("r08_resp", {62'h0, resp}, {62'h0, RESP_OKAY});

        // W three cycles ahead of AW
        bus.s_wvalid = 1'b1; bus.s_wdata = 32'h12345678; bus.s_wstrb = 4'hF;
        @(posedge clk); #1;
        bus.s_wvalid = 1'b0;
        check_eq("wfirst_wready", {63'h0, bus.s_wready}, 64'h0);
        check_eq("wfirst_awready", {63'h0, bus.s_awready}, 64'h1);
        check_eq("wfirst_bvalid", {63'h0, bus.s_bvalid}, 64'h0);
        repeat (2) begin
            @(posedge clk); #1;
        end
        check_eq("wfirst_wready_hold", {63'h0, bus.s_wready}, 64'h0);
        check_eq("wfirst_no_commit", {32'h0, reg_q[1*32 +: 32]}, 64'h0);
        bus.s_awvalid = 1'b1; bus.s_awaddr = 32'h04;
        @(posedge clk); #1;
        bus.s_awvalid = 1'b0;
        m[1] = 32'h12345678;
        check_eq("wfirst_bvalid_aw", {63'h0, bus.s_bvalid}, 64'h1);
        check_eq("wfirst_bresp", {62'h0, bus.s_bresp}, {62'h0, RESP_OKAY});
        check_eq("wfirst_reg1", {32'h0, reg_q[1*32 +: 32]}, 64'h12345678);
        bus.s_bready = 1'b1;
        @(posedge clk); #1;
        bus.s_bready = 1'b0;

        // Out-of-range write and reads
        axi_write(32'h40, 32'h55AA55AA, 4'hF, resp);
        check_eq("w40_bresp", {62'h0, resp}, {62'h0, RESP_SLVERR});
        check_regs("w40");
        axi_read(32'h40, rd, resp);
        check_eq("r40_data", {32'h0, rd}, 64'h0);
        check_eq("r40_resp", {62'h0, resp}, {62'h0, RESP_SLVERR});
        axi_read(32'h8000_0008, rd, resp);
        check_eq("rhi_data", {32'h0, rd}, 64'h0);
        check_eq("rhi_resp", {62'h0, resp}, {62'h0, RESP_SLVERR});

        // bready stalled for 5 cycles
        bus.s_awvalid = 1'b1; bus.s_awaddr = 32'h0C;
        bus.s_wvalid  = 1'b1; bus.s_wdata  = 32'hCAFE0001; bus.s_wstrb = 4'hF;
        @(posedge clk); #1;
        bus.s_awvalid = 1'b0; bus.s_wvalid = 1'b0;
        m[3] = 32'hCAFE0001;
        for (int i = 0; i < 5; i++) begin
            check_eq($sformatf("stall%0d_bvalid", i), {63'h0, bus.s_bvalid}, 64'h1);
            check_eq($sformatf("stall%0d_bresp", i), {62'h0, bus.s_bresp}, 64'h0);
            check_eq($sformatf("stall%0d_awready", i), {63'h0, bus.s_awready}, 64'h0);
            check_eq($sformatf("stall%0d_wready", i), {63'h0, bus.s_wready}, 64'h0);
            @(posedge clk); #1;
        end
        bus.s_bready = 1'b1;
        @(posedge clk); #1;
        bus.s_bready = 1'b0;
        check_eq("stall_bvalid_clr", {63'h0, bus.s_bvalid}, 64'h0);
        check_eq("stall_awready", {63'h0, bus.s_awready}, 64'h1);
        check_eq("stall_wready", {63'h0, bus.s_wready}, 64'h1);
        axi_write(32'h10, 32'h0BADF00D, 4'hF, resp);
        m[4] = 32'h0BADF00D;
        check_eq("w10_bresp", {62'h0, resp}, {62'h0, RESP_OKAY});
        check_regs("stall");

        // Byte strobes
        axi_write(32'h00, 32'hFFFFFFFF, 4'hF, resp);
        m[0] = 32'hFFFFFFFF;
        axi_write(32'h00, 32'h00000000, 4'h5, resp);
`ifdef AXIL_SLV_WSTRB_EN
        m[0] = 32'hFF00FF00;
`else
        m[0] = 32'h00000000;
`endif
        check_eq("strb5_reg0", {32'h0, reg_q[0 +: 32]}, {32'h0, m[0]});
        axi_write(32'h00, 32'h12345678, 4'h0, resp);
`ifndef AXIL_SLV_WSTRB_EN
        m[0] = 32'h12345678;
`endif
        check_eq("strb0_bresp", {62'h0, resp}, {62'h0, RESP_OKAY});
        check_eq("strb0_reg0", {32'h0, reg_q[0 +: 32]}, {32'h0, m[0]});

        // Same-cycle read and write to reg2: read sees old value
        bus.s_awvalid = 1'b1; bus.s_awaddr = 32'h08;
        bus.s_wvalid  = 1'b1; bus.s_wdata  = 32'h11111111; bus.s_wstrb = 4'hF;
        bus.s_arvalid = 1'b1; bus.s_araddr = 32'h08;
        @(posedge clk); #1;
        bus.s_awvalid = 1'b0; bus.s_wvalid = 1'b0; bus.s_arvalid = 1'b0;
        m[2] = 32'h11111111;
        check_eq("rw_rvalid", {63'h0, bus.s_rvalid}, 64'h1);
        check_eq("rw_rdata_old", {32'h0, bus.s_rdata}, 64'hDEADBEEF);
        check_eq("rw_bvalid", {63'h0, bus.s_bvalid}, 64'h1);
        check_eq("rw_reg2_new", {32'h0, reg_q[2*32 +: 32]}, 64'h11111111);
        bus.s_bready = 1'b1; bus.s_rready = 1'b1;
        @(posedge clk); #1;
        bus.s_bready = 1'b0; bus.s_rready = 1'b0;

        // Reset while R is pending and a W beat is held
        axi_write(32'h0C, 32'h000000A5, 4'hF, resp);
        m[3] = 32'h000000A5;
        bus.s_arvalid = 1'b1; bus.s_araddr = 32'h0C;
        bus.s_wvalid  = 1'b1; bus.s_wdata  = 32'h00000077; bus.s_wstrb = 4'hF;
        @(posedge clk); #1;
        bus.s_arvalid = 1'b0; bus.s_wvalid = 1'b0;
        check_eq("prerst_rvalid", {63'h0, bus.s_rvalid}, 64'h1);
        check_eq("prerst_rdata", {32'h0, bus.s_rdata}, 64'hA5);
        #2 rst_n = 1'b0;
        #1;
        for (int k = 0; k < 16; k++) m[k] = 32'h0;
        check_eq("midrst_rvalid", {63'h0, bus.s_rvalid}, 64'h0);
        check_eq("midrst_rdata", {32'h0, bus.s_rdata}, 64'h0);
        check_eq("midrst_reg3", {32'h0, reg_q[3*32 +: 32]}, 64'h0);
        check_readies("midrst", 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_readies("relrst", 1'b1);

        // The W beat held before reset must be gone: a lone AW does not commit
        bus.s_awvalid = 1'b1; bus.s_awaddr = 32'h14;
        @(posedge clk); #1;
        bus.s_awvalid = 1'b0;
        repeat (2) begin
            check_eq("awonly_bvalid", {63'h0, bus.s_bvalid}, 64'h0);
            check_eq("awonly_wready", {63'h0, bus.s_wready}, 64'h1);
            @(posedge clk); #1;
        end
        bus.s_wvalid = 1'b1; bus.s_wdata = 32'h00000099; bus.s_wstrb = 4'hF;
        @(posedge clk); #1;
        bus.s_wvalid = 1'b0;
        m[5] = 32'h00000099;
        check_eq("late_w_bvalid", {63'h0, bus.s_bvalid}, 64'h1);
        bus.s_bready = 1'b1;
        @(posedge clk); #1;
        bus.s_bready = 1'b0;
        check_regs("final");

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
